// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA scan path: default 640x480@60 timing, derived
// line/frame totals, the renderer coordinate width and the colour field
// positions inside the 24-bit {R,G,B} renderer word.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

  // Renderer coordinate width shared with the sprite/asteroid renderers.
  localparam int COORD_W = 19;

  // Default horizontal timing, in pixels.
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  // Default vertical timing, in lines.
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Colour field slice positions in the renderer word.
  localparam int RGB_W = 24;
  localparam int R_HI  = 23;
  localparam int R_LO  = 16;
  localparam int G_HI  = 15;
  localparam int G_LO  = 8;
  localparam int B_HI  = 7;
  localparam int B_LO  = 0;

  // Pixel divider counter width (enough for CLK_DIV up to 4).
  localparam int DIV_W = 2;

  // Raw timing flags, all active-high; the all-zero value means
  // "blank, sync inactive".
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } timing_t;

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Enable-gated shift register of DEPTH stages of WIDTH bits. Each stage clears
// to zero on reset. DEPTH = 0 degenerates to a wire.
// Ports:
//   clock - system clock
//   reset - asynchronous active-high reset
//   en    - shift enable (one stage per asserted cycle)
//   d     - data in
//   q     - data out, d delayed by DEPTH enabled cycles
// -----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_s;
    assign unused_s = ^{clock, reset, en};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift the stages forward on every enabled cycle.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= '0;
        end
      end else if (en) begin
        stage_r[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i];
        end
      end
    end

    assign q = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_controller.sv
// -----------------------------------------------------------------------------
// vga_scan_controller
// Free-running VGA raster generator. Presents the current pixel coordinate to
// the renderers, samples their colour RGB_LATENCY pixel ticks later and drives
// it to the DAC with hsync/vsync/blank aligned to the same pixel. Raises a
// one-clock frame_tick when the scan enters vertical blanking.
// Ports:
//   clock        - system clock
//   reset        - asynchronous active-high reset
//   x, y         - current pixel coordinate (registered)
//   pix_en       - pixel strobe; x/y advance on the cycle after it
//   rgb          - renderer colour {R,G,B} for the coordinate RGB_LATENCY ticks ago
//   vga_r/g/b    - registered colour to the DAC, zero outside the visible area
//   vga_hsync    - active-low horizontal sync
//   vga_vsync    - active-low vertical sync
//   vga_blank_n  - high while the visible region is on the pins
//   frame_tick   - one system-clock pulse at the start of vertical blanking
// -----------------------------------------------------------------------------
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int RGB_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pix_en,
  input  logic [RGB_W-1:0]   rgb,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_blank_n,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS_M1 = COORD_W'(V_VISIBLE - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div_r;
  logic               pix_en_r;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic [COORD_W-1:0] x_next_s;
  logic [COORD_W-1:0] y_next_s;
  logic               frame_tick_r;
  timing_t            raw_s;
  timing_t            dly_s;
  logic [7:0]         r_s;
  logic [7:0]         g_s;
  logic [7:0]         b_s;
  logic [7:0]         r_r;
  logic [7:0]         g_r;
  logic [7:0]         b_r;
  logic               hsync_r;
  logic               vsync_r;
  logic               blank_n_r;

  // Pixel divider. pix_en is registered so it is low in reset and the first
  // strobe lands CLK_DIV clocks after release; with CLK_DIV=1 it stays high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_r    <= '0;
      pix_en_r <= 1'b0;
    end else begin
      pix_en_r <= (div_r == DIV_LAST);
      if (div_r == DIV_LAST) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + 2'd1;
      end
    end
  end

  // Next raster position with line and frame wrap.
  always_comb begin
    x_next_s = x_r;
    y_next_s = y_r;
    if (x_r == H_LAST) begin
      x_next_s = '0;
      if (y_r == V_LAST) begin
        y_next_s = '0;
      end else begin
        y_next_s = y_r + 19'd1;
      end
    end else begin
      x_next_s = x_r + 19'd1;
    end
  end

  // Raster counters and the undelayed frame tick (fires on the step into
  // the first blanking line).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_r          <= '0;
      y_r          <= '0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= pix_en_r && (x_r == H_LAST) && (y_r == V_VIS_M1);
      if (pix_en_r) begin
        x_r <= x_next_s;
        y_r <= y_next_s;
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end
    end
  end

  // Raw timing decode of the presented coordinate.
  always_comb begin
    raw_s     = '0;
    raw_s.vis = (x_r < H_VIS) && (y_r < V_VIS);
    raw_s.hs  = (x_r >= HS_START) && (x_r < HS_END);
    raw_s.vs  = (y_r >= VS_START) && (y_r < VS_END);
  end

  // Delay the timing flags so they meet the renderer colour for the same pixel.
  vga_delay_line #(
    .DEPTH (RGB_LATENCY),
    .WIDTH ($bits(timing_t))
  ) u_timing_dly (
    .clock (clock),
    .reset (reset),
    .en    (pix_en_r),
    .d     (raw_s),
    .q     (dly_s)
  );

  // Colour is forced black outside the visible window.
  always_comb begin
    r_s = 8'd0;
    g_s = 8'd0;
    b_s = 8'd0;
    if (dly_s.vis) begin
      r_s = rgb[R_HI:R_LO];
      g_s = rgb[G_HI:G_LO];
      b_s = rgb[B_HI:B_LO];
    end else begin
      r_s = 8'd0;
      g_s = 8'd0;
      b_s = 8'd0;
    end
  end

  // DAC output register, loaded once per pixel tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_r       <= 8'd0;
      g_r       <= 8'd0;
      b_r       <= 8'd0;
      hsync_r   <= 1'b1;
      vsync_r   <= 1'b1;
      blank_n_r <= 1'b0;
    end else if (pix_en_r) begin
      r_r       <= r_s;
      g_r       <= g_s;
      b_r       <= b_s;
      hsync_r   <= ~dly_s.hs;
      vsync_r   <= ~dly_s.vs;
      blank_n_r <= dly_s.vis;
    end else begin
      r_r       <= r_r;
      g_r       <= g_r;
      b_r       <= b_r;
      hsync_r   <= hsync_r;
      vsync_r   <= vsync_r;
      blank_n_r <= blank_n_r;
    end
  end

  assign x           = x_r;
  assign y           = y_r;
  assign pix_en      = pix_en_r;
  assign frame_tick  = frame_tick_r;
  assign vga_r       = r_r;
  assign vga_g       = g_r;
  assign vga_b       = b_r;
  assign vga_hsync   = hsync_r;
  assign vga_vsync   = vsync_r;
  assign vga_blank_n = blank_n_r;

endmodule

// File: tb/tb_vga_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_controller
// Three scan controllers on a reduced raster (32x19 total, 20x12 visible) so
// several whole frames fit in a short run:
//   cfg 0: CLK_DIV=2, RGB_LATENCY=1 (colour garbled on non-strobe cycles)
//   cfg 1: CLK_DIV=1, RGB_LATENCY=0
//   cfg 2: CLK_DIV=1, RGB_LATENCY=3
// A bench-side raster model pushes the expected pin word for every presented
// pixel into a queue; the queue is pre-filled with RGB_LATENCY+1 reset words,
// so each popped entry is what the pins must show on that pixel tick.
// -----------------------------------------------------------------------------
module tb_vga_scan_controller;

  localparam int TH_VIS = 20;
  localparam int TH_FP  = 3;
  localparam int TH_SY  = 5;
  localparam int TH_BP  = 4;
  localparam int TV_VIS = 12;
  localparam int TV_FP  = 2;
  localparam int TV_SY  = 2;
  localparam int TV_BP  = 3;
  localparam int TH_TOT = TH_VIS + TH_FP + TH_SY + TH_BP;
  localparam int TV_TOT = TV_VIS + TV_FP + TV_SY + TV_BP;
  localparam int NCFG   = 3;

  // {r, g, b, hsync, vsync, blank_n}
  localparam logic [26:0] RST_PINS = {8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0};

  logic clock;
  logic reset;

  logic [18:0] x_w       [NCFG];
  logic [18:0] y_w       [NCFG];
  logic        pix_w     [NCFG];
  logic [23:0] rgb_w     [NCFG];
  logic [7:0]  r_w       [NCFG];
  logic [7:0]  g_w       [NCFG];
  logic [7:0]  b_w       [NCFG];
  logic        hs_w      [NCFG];
  logic        vs_w      [NCFG];
  logic        bn_w      [NCFG];
  logic        ft_w      [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input logic [18:0] px, input logic [18:0] py);
    return {px[7:0], py[7:0], 8'hA5};
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int CD  = (g == 0) ? 2 : 1;
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    logic [23:0] ren [4];
    logic [23:0] ren_val;

    vga_scan_controller #(
      .CLK_DIV     (CD),
      .H_VISIBLE   (TH_VIS),
      .H_FRONT     (TH_FP),
      .H_SYNC      (TH_SY),
      .H_BACK      (TH_BP),
      .V_VISIBLE   (TV_VIS),
      .V_FRONT     (TV_FP),
      .V_SYNC      (TV_SY),
      .V_BACK      (TV_BP),
      .RGB_LATENCY (LAT)
    ) dut (
      .clock       (clock),
      .reset       (reset),
      .x           (x_w[g]),
      .y           (y_w[g]),
      .pix_en      (pix_w[g]),
      .rgb         (rgb_w[g]),
      .vga_r       (r_w[g]),
      .vga_g       (g_w[g]),
      .vga_b       (b_w[g]),
      .vga_hsync   (hs_w[g]),
      .vga_vsync   (vs_w[g]),
      .vga_blank_n (bn_w[g]),
      .frame_tick  (ft_w[g])
    );

    // Renderer model: a LAT-deep colour pipe advanced on each pixel tick.
    always @(posedge clock) begin
      if (pix_w[g]) begin
        ren[0] <= pat(x_w[g], y_w[g]);
        for (int i = 1; i < 4; i++) ren[i] <= ren[i-1];
      end
    end

    assign ren_val  = (LAT == 0) ? pat(x_w[g], y_w[g]) : ren[(LAT > 0) ? LAT - 1 : 0];
    // Off-strobe cycles carry inverted colour; only the strobe cycle is valid.
    assign rgb_w[g] = pix_w[g] ? ren_val : ~ren_val;

    // Monitor / scoreboard.
    initial begin
      logic [26:0] sb [$];
      logic [26:0] exp_pins;
      logic [26:0] got_pins;
      int  mx, my, cyc, hlen, vlen;
      bit  prev_pix, exp_pix, vis, hs, vs;
      mx = 0; my = 0; cyc = 0; hlen = 0; vlen = 0; prev_pix = 1'b0;
      forever begin
        @(negedge clock);
        got_pins = {r_w[g], g_w[g], b_w[g], hs_w[g], vs_w[g], bn_w[g]};
        if (reset) begin
          check_val($sformatf("c%0d rst_x", g), 32'(x_w[g]), 32'd0);
          check_val($sformatf("c%0d rst_y", g), 32'(y_w[g]), 32'd0);
          check_val($sformatf("c%0d rst_pix_en", g), 32'(pix_w[g]), 32'd0);
          check_val($sformatf("c%0d rst_frame_tick", g), 32'(ft_w[g]), 32'd0);
          check_val($sformatf("c%0d rst_pins", g), 32'(got_pins), 32'(RST_PINS));
          mx = 0; my = 0; cyc = 0; hlen = 0; vlen = 0; prev_pix = 1'b0;
          sb.delete();
          for (int i = 0; i <= LAT; i++) sb.push_back(RST_PINS);
        end else begin
          cyc++;
          exp_pix = ((cyc % CD) == 0);
          check_val($sformatf("c%0d pix_en", g), 32'(pix_w[g]), 32'(exp_pix));
          check_val($sformatf("c%0d frame_tick", g), 32'(ft_w[g]),
                    32'(prev_pix && mx == 0 && my == TV_VIS));
          if (exp_pix) begin
            check_val($sformatf("c%0d x", g), 32'(x_w[g]), 32'(mx));
            check_val($sformatf("c%0d y", g), 32'(y_w[g]), 32'(my));
            vis = (mx < TH_VIS) && (my < TV_VIS);
            hs  = (mx >= TH_VIS + TH_FP) && (mx < TH_VIS + TH_FP + TH_SY);
            vs  = (my >= TV_VIS + TV_FP) && (my < TV_VIS + TV_FP + TV_SY);
            exp_pins = vis ? {8'(mx), 8'(my), 8'hA5, ~hs, ~vs, 1'b1}
                           : {8'd0, 8'd0, 8'd0, ~hs, ~vs, 1'b0};
            sb.push_back(exp_pins);
            exp_pins = sb.pop_front();
            check_val($sformatf("c%0d pins", g), 32'(got_pins), 32'(exp_pins));
            // Sync pulse widths measured directly on the pins.
            if (!hs_w[g]) begin
              hlen++;
            end else if (hlen != 0) begin
              check_val($sformatf("c%0d hsync_width", g), 32'(hlen), 32'(TH_SY));
              hlen = 0;
            end
            if (!vs_w[g]) begin
              vlen++;
            end else if (vlen != 0) begin
              check_val($sformatf("c%0d vsync_width", g), 32'(vlen), 32'(TV_SY * TH_TOT));
              vlen = 0;
            end
            mx++;
            if (mx == TH_TOT) begin
              mx = 0;
              my++;
              if (my == TV_TOT) my = 0;
            end
          end
          prev_pix = exp_pix;
        end
      end
    end
  end

  // Reset sequencing and mid-frame asynchronous reset.
  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    // Slightly over two frames of cfg 0 (1216 clocks each), stopping mid-frame.
    repeat (2800) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("c%0d async_x", i), 32'(x_w[i]), 32'd0);
      check_val($sformatf("c%0d async_y", i), 32'(y_w[i]), 32'd0);
      check_val($sformatf("c%0d async_pix_en", i), 32'(pix_w[i]), 32'd0);
      check_val($sformatf("c%0d async_pins", i),
                32'({r_w[i], g_w[i], b_w[i], hs_w[i], vs_w[i], bn_w[i]}), 32'(RST_PINS));
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (1500) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Drives the pixel-query interface consumed by the sprite/asteroid renderers.
- Generates 640x480@60 VGA timing and presents the current pixel coordinate (x, y).
- Samples the returned 24-bit rgb after a configurable renderer latency and drives it, with aligned hsync/vsync/blank, to the DAC.
- Issues a one-cycle frame_tick at the start of vertical blanking, so game logic can advance object positions once per frame.

Parameters:
- CLK_DIV, 2: system clocks per pixel. 50 MHz clock gives 25 MHz pixel rate. Legal values 1..4.
- H_VISIBLE, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal timing in pixels.
- V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical timing in lines.
- RGB_LATENCY, 1: pixel ticks between x/y presentation and valid rgb from the renderer. Legal values 0..3.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- x, output, 19: current horizontal pixel index, 0..H_total-1.
- y, output, 19: current vertical line index, 0..V_total-1.
- pix_en, output, 1: one-cycle strobe; x/y advance on the cycle after it.
- rgb, input, 24: renderer colour for the x/y presented RGB_LATENCY pixel ticks earlier, {R[23:16], G[15:8], B[7:0]}.
- vga_r, output, 8: registered red output.
- vga_g, output, 8: registered green output.
- vga_b, output, 8: registered blue output.
- vga_hsync, output, 1: active-low horizontal sync.
- vga_vsync, output, 1: active-low vertical sync.
- vga_blank_n, output, 1: high during the visible region.
- frame_tick, output, 1: single system-clock pulse per frame.

Behaviour:
- Reset values: x=0, y=0, divider=0, pix_en=0, vga_r/g/b=0, vga_hsync=1, vga_vsync=1, vga_blank_n=0, frame_tick=0. All delay pipelines clear to the "blank, sync inactive" state.
- Reset asserted mid-frame aborts the frame immediately. After release, the first pix_en occurs CLK_DIV cycles later, and scanning restarts at (0,0).
- Divider: counts 0..CLK_DIV-1. pix_en=1 when divider==CLK_DIV-1. With CLK_DIV=1, pix_en is constantly 1 after reset.
- Counter update on each pix_en:
  - x increments; at x==H_total-1 it wraps to 0 and y increments.
  - At y==V_total-1 with x==H_total-1, both wrap to 0.
  - H_total=800, V_total=525 at defaults.
- Raw timing is decoded combinationally from x/y:
  - vis = x<H_VISIBLE && y<V_VISIBLE.
  - hs = x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC).
  - vs = y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC).
- Alignment: vis/hs/vs pass through an RGB_LATENCY-deep shift register advanced only on pix_en. The output register then loads, on pix_en, the delayed signals and rgb (forced to 0 when delayed vis=0).
- Total x/y-to-pin latency is RGB_LATENCY+1 pixel ticks. Sync widths are exact: 96 pixel ticks for hsync, 2 lines for vsync.
- frame_tick asserts for exactly one clock on the pix_en at which x/y transition to (0, V_VISIBLE). It is not delayed by the pipeline.
- rgb is sampled only on pix_en and ignored otherwise. Renderers must hold rgb stable for the pixel period.
- No handshake backpressure: the scan is free-running and never stalls.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (H/V visible, porch, sync);
  - derived H_TOTAL/V_TOTAL;
  - the 24-bit colour field slice positions;
  - COORD_W=19, matching the renderer x/y width.
- One sub-module, vga_delay_line: parameterised depth and width, enable-gated shift register with async reset. It is used for the vis/hs/vs alignment pipe.

Test Plan:
- Reset then run 2 frames, CLK_DIV=2 -> pix_en every 2nd clock; x wraps 799->0 with y+1; y wraps 524->0 after 840000 clocks per frame.
- Hsync check -> vga_hsync low for exactly 96 pixel ticks (192 clocks), starting RGB_LATENCY+1 ticks after x==656. vga_vsync low for exactly 2 lines starting at line 490 (+ latency).
- rgb driven as {x[7:0], y[7:0], 8'hA5}, RGB_LATENCY=1 -> at visible pixel (10,20), pins show R=10, G=20, B=A5 two pixel ticks after x/y=(10,20). During blanking, pins are 0 regardless of rgb.
- frame_tick -> exactly one 1-clock pulse per frame, coincident with the transition to (0,480); none during reset.
- Assert reset at (300,200) for 3 clocks -> outputs go to reset values asynchronously (same cycle). After release, first pix_en after CLK_DIV clocks, x=1,y=0.
- Parameter sweep CLK_DIV=1, RGB_LATENCY=0 and 3 -> same frame geometry. Pin latency equals RGB_LATENCY+1 pixel ticks in every case.
